// File: rtl/clk_cfg_pkg.sv
// Shared types and defaults for the clk_gen cfg-port initiator.
package clk_cfg_pkg;

  localparam int unsigned CFG_ADDR_W = 2;
  localparam int unsigned CFG_DATA_W = 32;

  localparam logic CFG_WRITE = 1'b0;
  localparam logic CFG_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOCK_WAIT,
    ST_RSP
  } cfg_init_state_e;

endpackage

// File: rtl/clk_cfg_initiator.sv
// Initiator for one clk_gen cfg port: one valid/ready command at a time, four-phase
// req/ack toward the port, optional wait for clock lock, valid/ready response.
module clk_cfg_initiator
  import clk_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W       = CFG_ADDR_W,
  parameter int unsigned DATA_W       = CFG_DATA_W,
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned LOCK_TIMEOUT = 1023,
  parameter bit          WAIT_LOCK    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wrn_i,
  input  logic [ADDR_W-1:0] cmd_add_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              cfg_req_o,
  input  logic              cfg_ack_i,
  output logic [ADDR_W-1:0] cfg_add_o,
  output logic [DATA_W-1:0] cfg_data_o,
  output logic              cfg_wrn_o,
  input  logic [DATA_W-1:0] cfg_r_data_i,
  input  logic              cfg_lock_i,
  output logic              busy_o
);

  localparam int unsigned CNT_MAX   = (ACK_TIMEOUT > LOCK_TIMEOUT) ? ACK_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned ACK_LAST  = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
  localparam int unsigned LOCK_LAST = (LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1;

  cfg_init_state_e   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wrn_q, wrn_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      add_q       <= '0;
      data_q      <= '0;
      wrn_q       <= CFG_READ;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      add_q       <= add_d;
      data_q      <= data_d;
      wrn_q       <= wrn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state and next-output logic; the timeout counter saturates rather than wraps
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    add_d       = add_q;
    data_d      = data_q;
    wrn_d       = wrn_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;
    cmd_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A still-high ack from the previous handshake blocks a new request
        cmd_ready_o = !cfg_ack_i;
        if (cmd_valid_i && !cfg_ack_i) begin
          add_d   = cmd_add_i;
          data_d  = cmd_data_i;
          wrn_d   = cmd_wrn_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (cfg_ack_i) begin
          req_d     = 1'b0;
          rsp_err_d = 1'b0;
          if (wrn_q == CFG_READ) begin
            rdata_d     = cfg_r_data_i;
            rsp_valid_d = 1'b1;
            state_d     = ST_RSP;
          end else begin
            rdata_d = '0;
            if (WAIT_LOCK) begin
              cnt_d   = '0;
              state_d = ST_LOCK_WAIT;
            end else begin
              rsp_valid_d = 1'b1;
              state_d     = ST_RSP;
            end
          end
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_LAST))) begin
          req_d       = 1'b0;
          rsp_err_d   = 1'b1;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LOCK_WAIT: begin
        if (cfg_lock_i) begin
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if ((LOCK_TIMEOUT != 0) && (cnt_q == CNT_W'(LOCK_LAST))) begin
          rsp_err_d   = 1'b1;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign cfg_req_o   = req_q;
  assign cfg_add_o   = add_q;
  assign cfg_data_o  = data_q;
  assign cfg_wrn_o   = wrn_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_clk_cfg_initiator.sv
// Directed bench: initiator against a small model of the clk_gen soc cfg port.
module tb_clk_cfg_initiator;
  import clk_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // Main instance (short ack timeout) and its cfg-port model
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wrn = 1'b1;
  logic [1:0]  cmd_add = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cfg_req, cfg_ack, cfg_wrn, cfg_lock = 1'b1, busy;
  logic [1:0]  cfg_add;
  logic [31:0] cfg_data, cfg_r_data;
  logic        ack_en = 1'b1, ack_force = 1'b0;
  logic [31:0] regs [4];

  // Second instance (short lock timeout), ack echoes req
  logic        lt_cmd_valid = 1'b0, lt_cmd_ready, lt_rsp_valid, lt_rsp_err;
  logic [31:0] lt_rsp_rdata, lt_cfg_data;
  logic        lt_cfg_req, lt_cfg_wrn, lt_busy, lt_lock = 1'b0;
  logic [1:0]  lt_cfg_add;

  always #5 clk = ~clk;

  assign cfg_ack    = (cfg_req & ack_en) | ack_force;
  assign cfg_r_data = cfg_ack ? regs[cfg_add] : 32'h0;

  always @(posedge clk)
    if (cfg_req && cfg_ack && (cfg_wrn == CFG_WRITE)) regs[cfg_add] <= cfg_data;

  clk_cfg_initiator #(.ACK_TIMEOUT(8), .LOCK_TIMEOUT(1023)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wrn_i(cmd_wrn),
    .cmd_add_i(cmd_add), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .cfg_req_o(cfg_req), .cfg_ack_i(cfg_ack), .cfg_add_o(cfg_add), .cfg_data_o(cfg_data),
    .cfg_wrn_o(cfg_wrn), .cfg_r_data_i(cfg_r_data), .cfg_lock_i(cfg_lock), .busy_o(busy)
  );

  clk_cfg_initiator #(.ACK_TIMEOUT(255), .LOCK_TIMEOUT(4)) dut_lt (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_valid_i(lt_cmd_valid), .cmd_ready_o(lt_cmd_ready), .cmd_wrn_i(CFG_WRITE),
    .cmd_add_i(2'd1), .cmd_data_i(32'h0000_0001),
    .rsp_valid_o(lt_rsp_valid), .rsp_ready_i(1'b1), .rsp_rdata_o(lt_rsp_rdata),
    .rsp_err_o(lt_rsp_err),
    .cfg_req_o(lt_cfg_req), .cfg_ack_i(lt_cfg_req), .cfg_add_o(lt_cfg_add),
    .cfg_data_o(lt_cfg_data), .cfg_wrn_o(lt_cfg_wrn),
    .cfg_r_data_i(lt_cfg_req ? 32'hFFFF_FFFF : 32'h0), .cfg_lock_i(lt_lock), .busy_o(lt_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in the current cycle; returns one cycle later with valid dropped
  task automatic send(input logic wrn, input logic [1:0] add, input logic [31:0] data);
    cmd_valid = 1'b1; cmd_wrn = wrn; cmd_add = add; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++; if (cfg_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", cfg_req); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", rsp_rdata); end
    checks++; if (cfg_add !== 2'd0) begin errors++; $display("FAIL rst_add: got %h exp 0", cfg_add); end
    checks++; if (cfg_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", cfg_data); end
    checks++; if (cfg_wrn !== 1'b1) begin errors++; $display("FAIL rst_wrn: got %b exp 1", cfg_wrn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    rstn = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_read();
    send(CFG_READ, 2'd1, 32'h0);
    checks++; if (cfg_req !== 1'b1) begin errors++; $display("FAIL rd_req_c1: got %b exp 1", cfg_req); end
    checks++; if (cfg_add !== 2'd1 || cfg_wrn !== 1'b1) begin errors++; $display("FAIL rd_addr_wrn: got %h/%b exp 1/1", cfg_add, cfg_wrn); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_c1: got %b exp 0", rsp_valid); end
    tick();
    checks++; if (cfg_req !== 1'b0) begin errors++; $display("FAIL rd_req_c2: got %b exp 0", cfg_req); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_c2: got %b exp 1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0001_0002) begin errors++; $display("FAIL rd_rdata: got %h exp 00010002", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b exp 0", rsp_err); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_done: got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
  endtask

  task automatic test_write();
    cfg_lock = 1'b1;
    send(CFG_WRITE, 2'd0, 32'h1234_5678);
    checks++; if (cfg_req !== 1'b1 || cfg_wrn !== 1'b0) begin errors++; $display("FAIL wr_req: got req=%b wrn=%b exp 1/0", cfg_req, cfg_wrn); end
    checks++; if (cfg_data !== 32'h1234_5678 || cfg_add !== 2'd0) begin errors++; $display("FAIL wr_data: got %h@%h exp 12345678@0", cfg_data, cfg_add); end
    tick();
    checks++; if (cfg_req !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_lock_wait: got req=%b valid=%b busy=%b exp 0/0/1", cfg_req, rsp_valid, busy); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_valid_c3: got %b exp 1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got rdata=%h err=%b exp 0/0", rsp_rdata, rsp_err); end
    tick();
    checks++; if (regs[0] !== 32'h1234_5678) begin errors++; $display("FAIL wr_target: got %h exp 12345678", regs[0]); end
    send(CFG_READ, 2'd0, 32'h0);
    tick();
    checks++; if (rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_readback: got %h exp 12345678", rsp_rdata); end
    tick();
  endtask

  task automatic test_ack_timeout();
    int hi;
    hi = 0;
    ack_en = 1'b0;
    send(CFG_READ, 2'd2, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (!cfg_req) break;
      hi++;
      tick();
    end
    checks++; if (hi !== 8) begin errors++; $display("FAIL to_req_cycles: got %0d exp 8", hi); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp: got valid=%b err=%b exp 1/1", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h exp 0", rsp_rdata); end
    tick();
    ack_en = 1'b1;
  endtask

  task automatic test_ack_timeout_race();
    ack_en = 1'b0;
    cfg_lock = 1'b1;
    send(CFG_WRITE, 2'd3, 32'hDEAD_BEEF);
    repeat (7) tick();
    checks++; if (cfg_req !== 1'b1) begin errors++; $display("FAIL race_req_c8: got %b exp 1", cfg_req); end
    ack_en = 1'b1;
    tick();
    checks++; if (cfg_req !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL race_lock_wait: got req=%b valid=%b busy=%b exp 0/0/1", cfg_req, rsp_valid, busy); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL race_rsp: got valid=%b err=%b exp 1/0", rsp_valid, rsp_err); end
    tick();
    checks++; if (regs[3] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL race_target: got %h exp deadbeef", regs[3]); end
  endtask

  task automatic test_lock_wait();
    cfg_lock = 1'b0;
    send(CFG_WRITE, 2'd2, 32'h0BAD_F00D);
    tick();
    repeat (5) tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lock_hold: got valid=%b busy=%b exp 0/1", rsp_valid, busy); end
    cfg_lock = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL lock_rsp: got valid=%b err=%b rdata=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    // restore the target register used by later reads
    regs[2] = 32'hA5A5_0003;
  endtask

  task automatic test_lock_timeout();
    lt_lock = 1'b0;
    lt_cmd_valid = 1'b1;
    tick();
    lt_cmd_valid = 1'b0;
    checks++; if (lt_cfg_req !== 1'b1) begin errors++; $display("FAIL lto_req: got %b exp 1", lt_cfg_req); end
    repeat (4) tick();
    checks++; if (lt_rsp_valid !== 1'b0 || lt_busy !== 1'b1) begin errors++; $display("FAIL lto_wait: got valid=%b busy=%b exp 0/1", lt_rsp_valid, lt_busy); end
    tick();
    checks++; if (lt_rsp_valid !== 1'b1 || lt_rsp_err !== 1'b1) begin errors++; $display("FAIL lto_rsp: got valid=%b err=%b exp 1/1", lt_rsp_valid, lt_rsp_err); end
    checks++; if (lt_rsp_rdata !== 32'h0) begin errors++; $display("FAIL lto_rdata: got %h exp 0", lt_rsp_rdata); end
    tick();
    checks++; if (lt_rsp_valid !== 1'b0 || lt_busy !== 1'b0) begin errors++; $display("FAIL lto_done: got valid=%b busy=%b exp 0/0", lt_rsp_valid, lt_busy); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    send(CFG_READ, 2'd1, 32'h0);
    tick();
    cmd_valid = 1'b1; cmd_wrn = CFG_READ; cmd_add = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0001_0002) begin errors++; $display("FAIL bp_hold%0d: got valid=%b rdata=%h exp 1/00010002", i, rsp_valid, rsp_rdata); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b exp 0", i, cmd_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_exit: got ready=%b valid=%b exp 0/1", cmd_ready, rsp_valid); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0 || cfg_req !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_bubble: got valid=%b req=%b ready=%b exp 0/0/1", rsp_valid, cfg_req, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (cfg_req !== 1'b1 || cfg_add !== 2'd2) begin errors++; $display("FAIL bp_next_req: got req=%b add=%h exp 1/2", cfg_req, cfg_add); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0003) begin errors++; $display("FAIL bp_next_rsp: got valid=%b rdata=%h exp 1/a5a50003", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_ack_held();
    ack_force = 1'b1;
    cmd_valid = 1'b1; cmd_wrn = CFG_READ; cmd_add = 2'd1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ah_ready: got %b exp 0", cmd_ready); end
    tick();
    checks++; if (cfg_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ah_no_req: got req=%b busy=%b exp 0/0", cfg_req, busy); end
    ack_force = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ah_release: got %b exp 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (cfg_req !== 1'b1) begin errors++; $display("FAIL ah_req: got %b exp 1", cfg_req); end
    tick();
    checks++; if (rsp_rdata !== 32'h0001_0002) begin errors++; $display("FAIL ah_rdata: got %h exp 00010002", rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_req();
    int seen;
    seen = 0;
    ack_en = 1'b0;
    send(CFG_READ, 2'd1, 32'h0);
    tick();
    checks++; if (cfg_req !== 1'b1) begin errors++; $display("FAIL mr_req: got %b exp 1", cfg_req); end
    rstn = 1'b0;
    tick();
    checks++; if (cfg_req !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_abort: got req=%b busy=%b valid=%b exp 0/0/0", cfg_req, busy, rsp_valid); end
    checks++; if (cfg_wrn !== 1'b1 || cfg_add !== 2'd0) begin errors++; $display("FAIL mr_cfg: got wrn=%b add=%h exp 1/0", cfg_wrn, cfg_add); end
    rstn = 1'b1;
    ack_en = 1'b1;
    repeat (4) begin
      tick();
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mr_no_rsp: got %0d responses exp 0", seen); end
    send(CFG_READ, 2'd1, 32'h0);
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0001_0002 || rsp_err !== 1'b0) begin errors++; $display("FAIL mr_read: got valid=%b rdata=%h err=%b exp 1/00010002/0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
  endtask

  initial begin
    regs[0] = 32'h0; regs[1] = 32'h0001_0002; regs[2] = 32'hA5A5_0003; regs[3] = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_ack_timeout();
    test_ack_timeout_race();
    test_lock_wait();
    test_lock_timeout();
    test_back_to_back();
    test_ack_held();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
